// File: rtl/ov7670_config_sequencer.sv
// OV7670 configuration sequencer.
// Walks the 256x24 configuration table from entry 0 and turns each entry into
// one SCCB register write (valid/ready command, done/nack response). Entries
// whose device field is 8'hFF end the list. Entries whose device field is
// 8'hFE wait {reg,val} milliseconds. NACKed writes are retried a bounded
// number of times before the sequence aborts.
module ov7670_config_sequencer #(
  parameter int CLKS_PER_MS = 25000,
  parameter int RETRIES     = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic [7:0]  r_addr,
  input  logic [23:0] r_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_dev,
  output logic [7:0]  cmd_reg,
  output logic [7:0]  cmd_data,
  input  logic        cmd_done,
  input  logic        cmd_nack,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  err_index
);

  localparam logic [31:0] MS_CYCLES = 32'(CLKS_PER_MS);
  localparam logic [3:0]  RETRY_MAX = 4'(RETRIES);
  localparam logic [7:0]  DEV_END   = 8'hFF;
  localparam logic [7:0]  DEV_DELAY = 8'hFE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DELAY,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  r_addr_reg, r_addr_next;
  logic        cmd_valid_reg, cmd_valid_next;
  logic [7:0]  cmd_dev_reg, cmd_dev_next;
  logic [7:0]  cmd_reg_reg, cmd_reg_next;
  logic [7:0]  cmd_data_reg, cmd_data_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        error_reg, error_next;
  logic [7:0]  err_index_reg, err_index_next;
  logic [3:0]  retry_reg, retry_next;
  logic [31:0] delay_reg, delay_next;
  logic        advance;

  // Delay reload value: the counter runs down to 0 inclusive, so loading
  // D*CLKS_PER_MS-1 yields exactly D*CLKS_PER_MS cycles in DELAY.
  logic [31:0] delay_load;
  assign delay_load = (32'(r_data[15:0]) * MS_CYCLES) - 32'd1;

  // State and datapath registers; the async reset drops cmd_valid at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= S_IDLE;
      r_addr_reg    <= 8'd0;
      cmd_valid_reg <= 1'b0;
      cmd_dev_reg   <= 8'd0;
      cmd_reg_reg   <= 8'd0;
      cmd_data_reg  <= 8'd0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
      err_index_reg <= 8'd0;
      retry_reg     <= 4'd0;
      delay_reg     <= 32'd0;
    end else begin
      state_reg     <= state_next;
      r_addr_reg    <= r_addr_next;
      cmd_valid_reg <= cmd_valid_next;
      cmd_dev_reg   <= cmd_dev_next;
      cmd_reg_reg   <= cmd_reg_next;
      cmd_data_reg  <= cmd_data_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      error_reg     <= error_next;
      err_index_reg <= err_index_next;
      retry_reg     <= retry_next;
      delay_reg     <= delay_next;
    end
  end

  // Next-state and next-register logic; "advance" is the shared step to the
  // following entry (or to DONE after entry 255, the table never wraps).
  always_comb begin
    state_next     = state_reg;
    r_addr_next    = r_addr_reg;
    cmd_valid_next = cmd_valid_reg;
    cmd_dev_next   = cmd_dev_reg;
    cmd_reg_next   = cmd_reg_reg;
    cmd_data_next  = cmd_data_reg;
    busy_next      = busy_reg;
    done_next      = done_reg;
    error_next     = error_reg;
    err_index_next = err_index_reg;
    retry_next     = retry_reg;
    delay_next     = delay_reg;
    advance        = 1'b0;

    case (state_reg)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          r_addr_next = 8'd0;
          retry_next  = 4'd0;
          done_next   = 1'b0;
          error_next  = 1'b0;
          busy_next   = 1'b1;
          state_next  = S_FETCH;
        end
      end
      S_FETCH: begin
        if (r_data[23:16] == DEV_END) begin
          busy_next  = 1'b0;
          done_next  = 1'b1;
          state_next = S_DONE;
        end else if (r_data[23:16] == DEV_DELAY) begin
          if (r_data[15:0] == 16'd0) begin
            advance = 1'b1;
          end else begin
            delay_next = delay_load;
            state_next = S_DELAY;
          end
        end else begin
          cmd_dev_next   = r_data[23:16];
          cmd_reg_next   = r_data[15:8];
          cmd_data_next  = r_data[7:0];
          cmd_valid_next = 1'b1;
          state_next     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cmd_ready) begin
          cmd_valid_next = 1'b0;
          state_next     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cmd_done) begin
          if (!cmd_nack) begin
            advance = 1'b1;
          end else if (retry_reg < RETRY_MAX) begin
            retry_next     = retry_reg + 4'd1;
            cmd_valid_next = 1'b1;
            state_next     = S_ISSUE;
          end else begin
            err_index_next = r_addr_reg;
            busy_next      = 1'b0;
            error_next     = 1'b1;
            state_next     = S_ERR;
          end
        end
      end
      S_DELAY: begin
        if (delay_reg == 32'd0) begin
          advance = 1'b1;
        end else begin
          delay_next = delay_reg - 32'd1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (advance) begin
      if (r_addr_reg == 8'hFF) begin
        busy_next  = 1'b0;
        done_next  = 1'b1;
        state_next = S_DONE;
      end else begin
        r_addr_next = r_addr_reg + 8'd1;
        retry_next  = 4'd0;
        state_next  = S_FETCH;
      end
    end
  end

  assign r_addr    = r_addr_reg;
  assign cmd_valid = cmd_valid_reg;
  assign cmd_dev   = cmd_dev_reg;
  assign cmd_reg   = cmd_reg_reg;
  assign cmd_data  = cmd_data_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign error     = error_reg;
  assign err_index = err_index_reg;

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Bench for ov7670_config_sequencer: a combinational table memory, an SCCB
// responder that answers every accepted command three cycles later (with a
// per-entry NACK budget), a table-driven command-order test and hand-written
// sequences for delay timing, retries, back-pressure, full table and reset.
module tb_ov7670_config_sequencer;

  localparam int CLKS_PER_MS = 10;
  localparam int RETRIES     = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  r_addr;
  logic [23:0] r_data;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic [7:0]  cmd_dev, cmd_reg, cmd_data;
  logic        cmd_done = 1'b0;
  logic        cmd_nack = 1'b0;
  logic        busy, done, error;
  logic [7:0]  err_index;

  logic [23:0] mem [256];
  assign r_data = mem[r_addr];

  ov7670_config_sequencer #(
    .CLKS_PER_MS(CLKS_PER_MS),
    .RETRIES(RETRIES)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .r_addr(r_addr), .r_data(r_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
    .cmd_done(cmd_done), .cmd_nack(cmd_nack),
    .busy(busy), .done(done), .error(error), .err_index(err_index)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Command log written by the responder.
  int         log_cnt = 0;
  logic [7:0] log_addr [1024];
  logic [7:0] log_dev  [1024];
  logic [7:0] log_reg  [1024];
  logic [7:0] log_data [1024];
  int         nack_left [256];

  // Responder: sees the handshake at the rising edge, answers on falling edges.
  bit         hs;
  bit         pend = 1'b0;
  int         cnt = 0;
  logic [7:0] hs_addr, hs_dev, hs_reg, hs_data, nack_addr;
  always begin
    @(posedge clk);
    hs      = resetn && cmd_valid && cmd_ready;
    hs_addr = r_addr;
    hs_dev  = cmd_dev;
    hs_reg  = cmd_reg;
    hs_data = cmd_data;
    @(negedge clk);
    cmd_done = 1'b0;
    cmd_nack = 1'b0;
    if (hs) begin
      if (log_cnt < 1024) begin
        log_addr[log_cnt] = hs_addr;
        log_dev[log_cnt]  = hs_dev;
        log_reg[log_cnt]  = hs_reg;
        log_data[log_cnt] = hs_data;
      end
      $display("cmd  #%0d entry=%0d dev=%02h reg=%02h data=%02h", log_cnt, hs_addr, hs_dev, hs_reg, hs_data);
      log_cnt   = log_cnt + 1;
      pend      = 1'b1;
      cnt       = 3;
      nack_addr = hs_addr;
    end
    if (pend) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        pend     = 1'b0;
        cmd_done = 1'b1;
        if (nack_left[nack_addr] > 0) begin
          cmd_nack = 1'b1;
          nack_left[nack_addr] = nack_left[nack_addr] - 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  task automatic clear_table();
    for (int i = 0; i < 256; i++) begin
      mem[i]       = 24'hFF0000;
      nack_left[i] = 0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Edges after the start-sampling edge until cmd_valid is seen.
  task automatic wait_valid(input int limit, output int k);
    k = 0;
    while (!cmd_valid && k < limit) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic wait_finish(input string name, input int limit);
    int k;
    k = 0;
    while (busy && k < limit) begin
      @(negedge clk);
      k++;
    end
    check({name, "_not_timed_out"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_log(input int target, input int limit);
    int k;
    k = 0;
    while (log_cnt < target && k < limit) begin
      @(negedge clk);
      k++;
    end
    check("wait_log_reached", (log_cnt >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [23:0] entry;
    bit          issued;
    logic [7:0]  exp_dev;
    logic [7:0]  exp_reg;
    logic [7:0]  exp_data;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [6];
    int   base, k, n3;
    bit   ok;
    logic [7:0] iv;

    vecs[0] = '{24'h421280, 1'b1, 8'h42, 8'h12, 8'h80};
    vecs[1] = '{24'hFE0000, 1'b0, 8'h00, 8'h00, 8'h00};
    vecs[2] = '{24'h421101, 1'b1, 8'h42, 8'h11, 8'h01};
    vecs[3] = '{24'h213A04, 1'b1, 8'h21, 8'h3A, 8'h04};
    vecs[4] = '{24'h000000, 1'b1, 8'h00, 8'h00, 8'h00};
    vecs[5] = '{24'hFF0000, 1'b0, 8'h00, 8'h00, 8'h00};

    clear_table();
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check("rst_r_addr", {24'd0, r_addr}, 32'd0);
    check("rst_err_index", {24'd0, err_index}, 32'd0);
    check("rst_cmd_fields", {8'd0, cmd_dev, cmd_reg, cmd_data}, 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven command order, zero-delay entry, end marker
    for (int i = 0; i < 6; i++) mem[i] = vecs[i].entry;
    base = log_cnt;
    pulse_start();
    check("A_busy_after_start", {31'd0, busy}, 32'd1);
    check("A_valid_not_in_fetch", {31'd0, cmd_valid}, 32'd0);
    wait_valid(100, k);
    check("A_first_valid_latency", k, 32'd1);
    wait_finish("A", 500);
    k = base;
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].issued) begin
        check($sformatf("A_cmd%0d_index", i), {24'd0, log_addr[k]}, i);
        check($sformatf("A_cmd%0d_fields", i), {8'd0, log_dev[k], log_reg[k], log_data[k]},
              {8'd0, vecs[i].exp_dev, vecs[i].exp_reg, vecs[i].exp_data});
        k++;
      end
    end
    check("A_cmd_count", log_cnt - base, 32'd4);
    check("A_done", {29'd0, done, busy, error}, 32'h4);
    check("A_r_addr_at_end", {24'd0, r_addr}, 32'd5);

    // Delay entry of 2 ms at 10 clocks/ms
    clear_table();
    mem[0] = 24'hFE0002;
    mem[1] = 24'h42ABCD;
    base = log_cnt;
    pulse_start();
    wait_valid(200, k);
    check("B_delay_latency", k, 32'd22);
    wait_finish("B", 200);
    check("B_cmd_count", log_cnt - base, 32'd1);
    check("B_cmd_fields", {8'd0, log_dev[base], log_reg[base], log_data[base]}, 32'h0042ABCD);
    check("B_done", {31'd0, done}, 32'd1);

    // Two NACKs on entry 3 are absorbed by RETRIES=2
    clear_table();
    for (int i = 0; i < 4; i++) mem[i] = {8'h42, 8'(i), 8'h5A};
    nack_left[3] = 2;
    base = log_cnt;
    pulse_start();
    wait_finish("C1", 500);
    n3 = 0;
    for (int i = base; i < log_cnt; i++) if (log_addr[i] == 8'd3 && log_reg[i] == 8'd3) n3++;
    check("C1_cmd_count", log_cnt - base, 32'd6);
    check("C1_entry3_issues", n3, 32'd3);
    check("C1_done_error", {30'd0, done, error}, 32'h2);

    // Three NACKs on entry 3 abort the sequence
    nack_left[3] = 3;
    base = log_cnt;
    pulse_start();
    check("C2_start_clears_done", {31'd0, done}, 32'd0);
    wait_finish("C2", 500);
    check("C2_cmd_count", log_cnt - base, 32'd6);
    check("C2_error_done", {30'd0, error, done}, 32'h2);
    check("C2_err_index", {24'd0, err_index}, 32'd3);
    repeat (20) @(negedge clk);
    check("C2_no_more_cmds", log_cnt - base, 32'd6);
    check("C2_error_sticky", {31'd0, error}, 32'd1);

    // Back-pressure: cmd_ready low for 50 cycles
    clear_table();
    mem[0] = 24'h4255AA;
    cmd_ready = 1'b0;
    base = log_cnt;
    pulse_start();
    check("D_start_clears_error", {31'd0, error}, 32'd0);
    wait_valid(100, k);
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (!(cmd_valid && cmd_dev == 8'h42 && cmd_reg == 8'h55 && cmd_data == 8'hAA)) ok = 1'b0;
      @(negedge clk);
    end
    check("D_hold_stable", {31'd0, ok}, 32'd1);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    check("D_valid_drops", {31'd0, cmd_valid}, 32'd0);
    wait_finish("D", 200);
    check("D_cmd_count", log_cnt - base, 32'd1);
    cmd_ready = 1'b1;

    // All 256 entries are writes; a start coincident with cmd_done is ignored
    for (int i = 0; i < 256; i++) begin
      iv = 8'(i);
      mem[i] = {8'h42, iv, ~iv};
      nack_left[i] = 0;
    end
    base = log_cnt;
    pulse_start();
    wait_log(base + 100, 2000);
    k = 0;
    @(negedge clk);
    #1;
    while (!cmd_done && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("E_saw_cmd_done", {31'd0, cmd_done}, 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_finish("E", 5000);
    ok = 1'b1;
    for (int i = 0; i < 256; i++) begin
      iv = 8'(i);
      if (log_addr[base + i] != iv || log_reg[base + i] != iv || log_data[base + i] != ~iv) ok = 1'b0;
    end
    check("E_cmd_count", log_cnt - base, 32'd256);
    check("E_order", {31'd0, ok}, 32'd1);
    check("E_done", {30'd0, done, error}, 32'h2);
    repeat (10) @(negedge clk);
    check("E_r_addr_no_wrap", {24'd0, r_addr}, 32'hFF);
    check("E_no_extra_cmds", log_cnt - base, 32'd256);

    // Reset during WAIT of entry 5, then restart from entry 0
    clear_table();
    for (int i = 0; i < 10; i++) mem[i] = {8'h42, 8'(i), 8'(i + 16)};
    base = log_cnt;
    pulse_start();
    wait_log(base + 6, 500);
    #2;
    resetn = 1'b0;
    #1;
    check("F_rst_busy", {31'd0, busy}, 32'd0);
    check("F_rst_r_addr", {24'd0, r_addr}, 32'd0);
    check("F_rst_fields", {7'd0, cmd_valid, cmd_dev, cmd_reg, cmd_data}, 32'd0);
    check("F_rst_flags", {29'd0, done, error, busy}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    base = log_cnt;
    pulse_start();
    wait_finish("F", 1000);
    check("F_restart_entry0", {24'd0, log_addr[base]}, 32'd0);
    check("F_cmd_count", log_cnt - base, 32'd10);
    check("F_done", {31'd0, done}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
